// File: rtl/fpna_cfg_loader.sv
// Serialises 8-bit host configuration words onto a slow cfg_clk/cfg_data link, MSB first,
// and strobes cfg_latch after the last word of a frame.
module fpna_cfg_loader #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       cfg_clk,
  output logic       cfg_data,
  output logic       cfg_latch,
  output logic       busy,
  output logic [7:0] word_cnt
);

  typedef enum logic [1:0] {StIdle, StShiftLo, StShiftHi, StLatch} state_e;

  localparam logic [3:0] DivLast = 4'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic       last_q, last_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] div_q, div_d;
  logic [7:0] word_cnt_q, word_cnt_d;
  logic       div_last;

  assign div_last = (div_q == DivLast);
  assign word_cnt = word_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= 8'h00;
      last_q     <= 1'b0;
      bit_cnt_q  <= 3'd0;
      div_q      <= 4'd0;
      word_cnt_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    word_cnt_d = word_cnt_q;
    // Gated by rst so the host never sees a ready while reset is held.
    in_ready   = (state_q == StIdle) && !rst;
    busy       = (state_q != StIdle);
    cfg_clk    = 1'b0;
    cfg_data   = 1'b0;
    cfg_latch  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          shreg_d   = in_data;
          last_d    = in_last;
          bit_cnt_d = 3'd0;
          div_d     = 4'd0;
          state_d   = StShiftLo;
        end
      end
      StShiftLo: begin
        cfg_data = shreg_q[7];
        if (div_last) begin
          div_d   = 4'd0;
          state_d = StShiftHi;
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      StShiftHi: begin
        cfg_clk  = 1'b1;
        cfg_data = shreg_q[7];
        if (div_last) begin
          // Shift only on leaving the high phase so data never moves while cfg_clk is high.
          div_d     = 4'd0;
          shreg_d   = {shreg_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            word_cnt_d = word_cnt_q + 8'd1;
            state_d    = last_q ? StLatch : StIdle;
          end else begin
            state_d = StShiftLo;
          end
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      StLatch: begin
        cfg_latch = 1'b1;
        if (div_last) begin
          div_d      = 4'd0;
          word_cnt_d = 8'h00;
          state_d    = StIdle;
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_fpna_cfg_loader.sv
// Randomised bench for fpna_cfg_loader: a queue-based model of the serial link checks bits,
// busy run lengths, word counts and latch strobes for CLK_DIV=2 and CLK_DIV=1 instances.
module tb_fpna_cfg_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       v_a = 1'b0, l_a = 1'b0, r_a, ck_a, d_a, la_a, b_a;
  logic [7:0] dt_a = 8'h00, wc_a;
  logic       v_b = 1'b0, l_b = 1'b0, r_b, ck_b, d_b, la_b, b_b;
  logic [7:0] dt_b = 8'h00, wc_b;

  fpna_cfg_loader #(.CLK_DIV(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(v_a), .in_ready(r_a), .in_data(dt_a), .in_last(l_a),
    .cfg_clk(ck_a), .cfg_data(d_a), .cfg_latch(la_a), .busy(b_a), .word_cnt(wc_a)
  );

  fpna_cfg_loader #(.CLK_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(v_b), .in_ready(r_b), .in_data(dt_b), .in_last(l_b),
    .cfg_clk(ck_b), .cfg_data(d_b), .cfg_latch(la_b), .busy(b_b), .word_cnt(wc_b)
  );

  int         sel = 0;
  int         cur_div = 2;
  logic       m_ready, m_clk, m_data, m_latch, m_busy;
  logic [7:0] m_wc;

  always_comb begin
    m_ready = (sel == 0) ? r_a  : r_b;
    m_clk   = (sel == 0) ? ck_a : ck_b;
    m_data  = (sel == 0) ? d_a  : d_b;
    m_latch = (sel == 0) ? la_a : la_b;
    m_busy  = (sel == 0) ? b_a  : b_b;
    m_wc    = (sel == 0) ? wc_a : wc_b;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference model: what the chip should see, per word and per frame.
  bit exp_bits[$], obs_bits[$];
  int exp_runs[$], obs_runs[$];
  int exp_wc[$],   obs_wc[$];
  int exp_lat[$],  obs_lat[$];
  int exp_lwc[$],  obs_lwc[$];
  int model_wc = 0;
  logic [7:0] stim[$];

  // Link monitor, sampled on the falling clk edge.
  initial begin
    logic prev_clk, held;
    int run, lrun, cyc, last_rise;
    bit rise_seen;
    prev_clk = 1'b0; held = 1'b0; run = 0; lrun = 0; cyc = 0; last_rise = 0; rise_seen = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_clk = 1'b0; run = 0; lrun = 0; rise_seen = 0;
      end else begin
        if (m_clk && !prev_clk) begin
          obs_bits.push_back(m_data);
          held = m_data;
          if (rise_seen) check_eq("cfg_clk_period", cyc - last_rise, 2 * cur_div);
          last_rise = cyc;
          rise_seen = 1;
        end else if (m_clk) begin
          check_eq("data_stable_hi", 32'(m_data), 32'(held));
        end
        if (m_latch) check_eq("latch_clk_overlap", 32'(m_clk), 0);
        if (m_latch && lrun == 0) obs_lwc.push_back(int'(m_wc));
        if (m_latch) lrun++;
        else if (lrun > 0) begin
          obs_lat.push_back(lrun);
          lrun = 0;
        end
        if (m_busy) run++;
        else if (run > 0) begin
          obs_runs.push_back(run);
          obs_wc.push_back(int'(m_wc));
          run = 0;
          rise_seen = 0;
        end
        prev_clk = m_clk;
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    if (sel == 0) begin
      v_a = v; dt_a = d; l_a = l;
    end else begin
      v_b = v; dt_b = d; l_b = l;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic select_dut(input int u);
    sel = u;
    cur_div = (u == 0) ? 2 : 1;
    model_wc = 0;
  endtask

  // Offers one word, then scribbles random inputs for the whole time the word is in flight.
  task automatic send_word(input logic [7:0] d, input bit l, output int waits);
    @(negedge clk);
    drive(1'b1, d, l);
    waits = 0;
    while (!m_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!m_ready) begin
      check_eq("ready_timeout", 32'(m_ready), 1);
      drive(1'b0, 8'h00, 1'b0);
      return;
    end
    @(posedge clk);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
    model_wc = (model_wc + 1) % 256;
    if (l) begin
      exp_runs.push_back(17 * cur_div);
      exp_lat.push_back(cur_div);
      exp_lwc.push_back(model_wc);
      model_wc = 0;
    end else begin
      exp_runs.push_back(16 * cur_div);
    end
    exp_wc.push_back(model_wc);
    for (int k = 0; k < 16 * cur_div; k++) begin
      @(negedge clk);
      check_eq("ready_low_busy", 32'(m_ready), 0);
      drive(1'($urandom), 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic compare_all();
    idle(3 * cur_div + 4);
    check_eq("bit_count", obs_bits.size(), exp_bits.size());
    for (int i = 0; i < exp_bits.size() && i < obs_bits.size(); i++)
      check_eq($sformatf("bit%0d", i), 32'(obs_bits[i]), 32'(exp_bits[i]));
    check_eq("run_count", obs_runs.size(), exp_runs.size());
    for (int i = 0; i < exp_runs.size() && i < obs_runs.size(); i++)
      check_eq($sformatf("busy_run%0d", i), obs_runs[i], exp_runs[i]);
    for (int i = 0; i < exp_wc.size() && i < obs_wc.size(); i++)
      check_eq($sformatf("word_cnt%0d", i), obs_wc[i], exp_wc[i]);
    check_eq("latch_count", obs_lat.size(), exp_lat.size());
    for (int i = 0; i < exp_lat.size() && i < obs_lat.size(); i++)
      check_eq($sformatf("latch_len%0d", i), obs_lat[i], exp_lat[i]);
    for (int i = 0; i < exp_lwc.size() && i < obs_lwc.size(); i++)
      check_eq($sformatf("latch_wc%0d", i), obs_lwc[i], exp_lwc[i]);
    exp_bits.delete(); obs_bits.delete(); exp_runs.delete(); obs_runs.delete();
    exp_wc.delete(); obs_wc.delete(); exp_lat.delete(); obs_lat.delete();
    exp_lwc.delete(); obs_lwc.delete();
  endtask

  task automatic run_frame(input bit end_last);
    int w;
    for (int i = 0; i < stim.size(); i++) begin
      send_word(stim[i], end_last && (i == stim.size() - 1), w);
      if (i > 0) check_eq("b2b_gap", w, 0);
    end
    compare_all();
    stim.delete();
  endtask

  task automatic rand_frames(input int n);
    repeat (n) begin
      int len;
      len = $urandom_range(1, 5);
      repeat (len) stim.push_back(8'($urandom));
      run_frame(1'b1);
    end
  endtask

  task automatic reset_midword();
    int t;
    logic [7:0] c;
    c = 8'hC3;
    @(negedge clk);
    drive(1'b1, c, 1'b1);
    check_eq("rst_pre_ready", 32'(m_ready), 1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1);
    t = 0;
    while (obs_bits.size() < 3 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check_eq("rst_pre_bits", obs_bits.size(), 3);
    for (int i = 0; i < 3 && i < obs_bits.size(); i++)
      check_eq($sformatf("rst_part_bit%0d", i), 32'(obs_bits[i]), 32'(c[7-i]));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_ready", 32'(m_ready), 0);
    check_eq("rst_cfg_clk", 32'(m_clk), 0);
    check_eq("rst_cfg_data", 32'(m_data), 0);
    check_eq("rst_cfg_latch", 32'(m_latch), 0);
    check_eq("rst_busy", 32'(m_busy), 0);
    check_eq("rst_word_cnt", 32'(m_wc), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(m_ready), 1);
    idle(3 * cur_div + 4);
    check_eq("no_latch_on_rst", obs_lat.size(), 0);
    obs_bits.delete(); obs_runs.delete(); obs_wc.delete(); obs_lat.delete(); obs_lwc.delete();
    model_wc = 0;
    stim.push_back(8'h81);
    run_frame(1'b1);
  endtask

  initial begin
    int w;
    #1 rst = 1'b1;
    #1;
    check_eq("init_ready_a", 32'(r_a), 0);
    check_eq("init_busy_a", 32'(b_a), 0);
    check_eq("init_cfg_a", 32'({ck_a, d_a, la_a}), 0);
    check_eq("init_wc_a", 32'(wc_a), 0);
    check_eq("init_ready_b", 32'(r_b), 0);
    check_eq("init_wc_b", 32'(wc_b), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_init", 32'(r_a), 1);

    select_dut(0);
    stim.push_back(8'hA5);
    run_frame(1'b1);
    stim.push_back(8'h3C); stim.push_back(8'hFF); stim.push_back(8'h01);
    run_frame(1'b1);
    stim.push_back(8'hFF);
    run_frame(1'b1);
    rand_frames(4);
    reset_midword();

    select_dut(1);
    stim.push_back(8'hA5);
    run_frame(1'b1);
    for (int i = 0; i < 260; i++) begin
      send_word(8'h55, 1'b0, w);
      if (i > 0) check_eq("cont_gap", w, 0);
    end
    compare_all();
    rand_frames(4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
